alu_issue_seq: RTL

Instruction-side issue sequencer for the execute stage: accepts one decoded-ready MIPS instruction plus its two register operands via valid/ready, translates opcode/funct into the 4-bit ALUOp code, and drives operands and shamt to the ALU. It captures the ALU's negedge-computed result and zero flag on the following rising edge and presents a writeback/branch record downstream with valid/ready backpressure. It sits between register-file read and writeback, directly in front of the execute ALU.

---
 rtl/alu_issue_seq_if.sv | 34 +++
 rtl/alu_issue_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq_if.sv
// Issue-side bundle for alu_issue_seq: instruction intake, ALU drive/capture and writeback record.
// The slave modport is the sequencer's view; master is the surrounding pipeline/ALU view.
interface alu_issue_seq_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_rs;
    logic [31:0] alu_rt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_we;
    logic        branch_taken;
    logic        illegal;

    modport slave (
        input  instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, wb_ready,
        output instr_ready, alu_op, alu_shamt, alu_rs, alu_rt,
        output wb_valid, wb_data, wb_reg, wb_we, branch_taken, illegal
    );

    modport master (
        output instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, wb_ready,
        input  instr_ready, alu_op, alu_shamt, alu_rs, alu_rt,
        input  wb_valid, wb_data, wb_reg, wb_we, branch_taken, illegal
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Execute-stage issue sequencer: decodes a MIPS instruction to an ALUOp, drives the ALU for one
// cycle, captures its negedge result and presents a writeback/branch record under valid/ready.
module alu_issue_seq (
    input  logic          clock,
    input  logic          reset_n,
    alu_issue_seq_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned OPW = 4;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state;
    logic            is_branch;
    logic            accept;

    logic [OPW-1:0]  dec_op;
    logic [RW-1:0]   dec_reg;
    logic            dec_branch;
    logic            dec_illegal;
    logic            dec_lui;
    logic            dec_we;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [RW-1:0]   rt_idx;
    logic            unused_rs_field;

    assign opcode          = bus.instr[31:26];
    assign funct           = bus.instr[5:0];
    assign rt_idx          = bus.instr[20:16];
    assign unused_rs_field = ^bus.instr[25:21];

    // Ready is a pure function of state and downstream ready, forced low while in reset.
    assign bus.instr_ready = reset_n & ((state == IDLE) | ((state == DONE) & bus.wb_ready));
    assign accept          = bus.instr_valid & bus.instr_ready;

    // Opcode/funct to ALUOp and writeback class.
    always_comb begin
        dec_op      = '0;
        dec_reg     = '0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        dec_lui     = 1'b0;
        case (opcode)
            6'h00: begin
                dec_reg = bus.instr[15:11];
                case (funct)
                    6'h20:   dec_op = 4'b0001;
                    6'h21:   dec_op = 4'b1010;
                    6'h22:   dec_op = 4'b1011; // 0010 is the BEQ compare, so SUB issues SUBU
                    6'h23:   dec_op = 4'b1011;
                    6'h24:   dec_op = 4'b0011;
                    6'h25:   dec_op = 4'b0100;
                    6'h27:   dec_op = 4'b0101;
                    6'h2A:   dec_op = 4'b0110;
                    6'h00:   dec_op = 4'b0111;
                    6'h02:   dec_op = 4'b1000;
                    6'h03:   dec_op = 4'b1001;
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h0F: begin
                dec_op  = 4'b1111;
                dec_reg = rt_idx;
                dec_lui = 1'b1;
            end
            6'h04: begin
                dec_op     = 4'b0010;
                dec_branch = 1'b1;
            end
            6'h05: begin
                dec_op     = 4'b1110;
                dec_branch = 1'b1;
            end
            6'h07: begin
                dec_op     = 4'b1100;
                dec_branch = 1'b1;
            end
            6'h01: begin
                if (rt_idx == RW'(1)) begin
                    dec_op     = 4'b1101;
                    dec_branch = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_op  = '0;
            dec_reg = '0;
        end
        dec_we = ~dec_branch & ~dec_illegal & (dec_reg != '0);
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            is_branch        <= 1'b0;
            bus.alu_op       <= '0;
            bus.alu_shamt    <= '0;
            bus.alu_rs       <= '0;
            bus.alu_rt       <= '0;
            bus.wb_data      <= '0;
            bus.wb_reg       <= '0;
            bus.wb_valid     <= 1'b0;
            bus.wb_we        <= 1'b0;
            bus.branch_taken <= 1'b0;
            bus.illegal      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state <= EXEC;
                end
                EXEC: begin
                    bus.alu_op       <= '0;
                    bus.wb_data      <= bus.alu_result;
                    bus.branch_taken <= is_branch & bus.alu_zero;
                    bus.wb_valid     <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        state        <= bus.instr_valid ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Operands and decode are frozen at accept; later input changes are ignored.
            if (accept) begin
                bus.alu_op    <= dec_op;
                bus.alu_shamt <= bus.instr[10:6];
                bus.alu_rs    <= bus.rs_data;
                bus.alu_rt    <= dec_lui ? {16'h0000, bus.instr[15:0]} : bus.rt_data;
                bus.wb_reg    <= dec_reg;
                bus.wb_we     <= dec_we;
                bus.illegal   <= dec_illegal;
                is_branch     <= dec_branch;
            end
        end
    end
endmodule
